// File: rtl/pipe_trace_buffer.sv
// Circular on-chip capture of pipeline writeback events with free-run, trigger-stop
// and fill-stop modes, read back by age-relative index through a 1-cycle port.
module pipe_trace_buffer #(
    parameter int unsigned PC_W       = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned POST_TRIG  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [PC_W-1:0]       trig_pc,
    input  logic                  sample_valid,
    input  logic [PC_W-1:0]       sample_pc,
    input  logic [4:0]            sample_opcode,
    input  logic [DATA_W-1:0]     sample_data,
    input  logic                  rd_req,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [PC_W-1:0]       rd_pc,
    output logic [4:0]            rd_opcode,
    output logic [DATA_W-1:0]     rd_data,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  triggered,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned ENT_W = PC_W + 5 + DATA_W;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_TRIG = 2'd1;
    localparam logic [1:0] MODE_FILL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               en_q;
    logic [1:0]         mode_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   post_cnt;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               restart_c;
    logic               wr_en_c;
    logic               full_c;
    logic               trig_hit_c;
    logic               post_last_c;
    logic               fill_last_c;
    logic               rd_hit_c;
    logic [PTR_W-1:0]   rd_addr_c;

    // Next-state and capture control decode.
    always_comb begin
        state_d     = state_q;
        restart_c   = 1'b0;
        wr_en_c     = 1'b0;
        full_c      = 1'b0;
        trig_hit_c  = 1'b0;
        post_last_c = 1'b0;
        fill_last_c = 1'b0;

        restart_c   = enable && !en_q && (state_q == S_IDLE || state_q == S_DONE);
        full_c      = (count == CNT_W'(DEPTH));
        wr_en_c     = sample_valid && (state_q == S_ARMED || state_q == S_POST);
        trig_hit_c  = wr_en_c && (state_q == S_ARMED) && (mode_q == MODE_TRIG)
                      && (sample_pc == trig_pc);
        post_last_c = wr_en_c && (state_q == S_POST)
                      && ((CNT_W'(post_cnt) + CNT_W'(1)) == CNT_W'(POST_TRIG));
        fill_last_c = wr_en_c && (mode_q == MODE_FILL) && (count == CNT_W'(DEPTH - 1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (restart_c) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!enable)          state_d = S_IDLE;
                else if (trig_hit_c)  state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                else if (fill_last_c) state_d = S_DONE;
            end
            S_POST: begin
                if (!enable)          state_d = S_IDLE;
                else if (post_last_c) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture bookkeeping: pointers, fill count and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_FREE;
            wr_ptr    <= '0;
            post_cnt  <= '0;
            count     <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            en_q <= enable;
            if (restart_c) begin
                mode_q    <= (mode == 2'd3) ? MODE_FREE : mode;
                wr_ptr    <= '0;
                post_cnt  <= '0;
                count     <= '0;
                triggered <= 1'b0;
                overflow  <= 1'b0;
            end else if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full_c) overflow <= 1'b1;
                else        count    <= count + CNT_W'(1);
                if (trig_hit_c) begin
                    triggered <= 1'b1;
                    post_cnt  <= '0;
                end else if (state_q == S_POST) begin
                    post_cnt <= post_cnt + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= {sample_pc, sample_opcode, sample_data};
    end

    // Index 0 is the oldest entry; the RAM read sees pre-write contents.
    assign rd_addr_c = wr_ptr - count[PTR_W-1:0] + rd_idx;
    assign rd_hit_c  = (CNT_W'(rd_idx) < count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_pc     <= '0;
            rd_opcode <= '0;
            rd_data   <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (rd_hit_c) begin
                    {rd_pc, rd_opcode, rd_data} <= mem[rd_addr_c];
                    rd_err <= 1'b0;
                end else begin
                    rd_pc     <= '0;
                    rd_opcode <= '0;
                    rd_data   <= '0;
                    rd_err    <= 1'b1;
                end
            end else begin
                rd_err <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: capture modes, flags and indexed readback.
module tb_pipe_trace_buffer;

    localparam int unsigned PC_W   = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DL2    = 4;
    localparam int unsigned DEPTH  = 16;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        op;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct packed {
        logic err;
        ent_t ent;
    } rd_exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        mode;
    logic [PC_W-1:0]   trig_pc;
    logic              sample_valid;
    logic [PC_W-1:0]   sample_pc;
    logic [4:0]        sample_opcode;
    logic [DATA_W-1:0] sample_data;
    logic              rd_req;
    logic [DL2-1:0]    rd_idx;

    logic              rd_valid, rd_err, triggered, overflow;
    logic [PC_W-1:0]   rd_pc;
    logic [4:0]        rd_opcode;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        state;
    logic [DL2:0]      count;

    logic              z_rd_valid, z_rd_err, z_triggered, z_overflow;
    logic [PC_W-1:0]   z_rd_pc;
    logic [4:0]        z_rd_opcode;
    logic [DATA_W-1:0] z_rd_data;
    logic [1:0]        z_state;
    logic [DL2:0]      z_count;

    int n_chk = 0;
    int n_err = 0;
    rd_exp_t exp_q[$];
    ent_t    mdl[$];
    logic    req_prev = 1'b0;

    pipe_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL2), .POST_TRIG(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trig_pc(trig_pc),
        .sample_valid(sample_valid), .sample_pc(sample_pc), .sample_opcode(sample_opcode),
        .sample_data(sample_data), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_err(rd_err), .rd_pc(rd_pc), .rd_opcode(rd_opcode),
        .rd_data(rd_data), .state(state), .count(count), .triggered(triggered),
        .overflow(overflow)
    );

    // Zero post-trigger instance sharing the same stimulus.
    pipe_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL2), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trig_pc(trig_pc),
        .sample_valid(sample_valid), .sample_pc(sample_pc), .sample_opcode(sample_opcode),
        .sample_data(sample_data), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(z_rd_valid), .rd_err(z_rd_err), .rd_pc(z_rd_pc), .rd_opcode(z_rd_opcode),
        .rd_data(z_rd_data), .state(z_state), .count(z_count), .triggered(z_triggered),
        .overflow(z_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ent_t mk_ent(input int pc);
        ent_t e;
        e.pc   = PC_W'(pc);
        e.op   = 5'(pc * 7 + 1);
        e.data = 32'hD0D0_0000 + DATA_W'(pc) * 32'd3;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pc, input logic v);
        ent_t e;
        e             = mk_ent(pc);
        sample_valid  = v;
        sample_pc     = e.pc;
        sample_opcode = e.op;
        sample_data   = e.data;
        step();
        sample_valid  = 1'b0;
    endtask

    task automatic mdl_push(input int pc);
        mdl.push_back(mk_ent(pc));
        if (mdl.size() > DEPTH) void'(mdl.pop_front());
    endtask

    task automatic start(input logic [1:0] m);
        enable = 1'b0;
        step();
        mode   = m;
        enable = 1'b1;
        step();
        mdl.delete();
    endtask

    task automatic rd(input int idx);
        rd_exp_t x;
        if (idx < mdl.size()) begin
            x.err = 1'b0;
            x.ent = mdl[idx];
        end else begin
            x.err = 1'b1;
            x.ent = '0;
        end
        exp_q.push_back(x);
        rd_req = 1'b1;
        rd_idx = DL2'(idx);
        step();
        rd_req = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int st, input int cnt,
                              input logic trg, input logic ovf);
        check({tag, "_state"}, 64'(state), 64'(st));
        check({tag, "_count"}, 64'(count), 64'(cnt));
        check({tag, "_trig"},  64'(triggered), 64'(trg));
        check({tag, "_ovf"},   64'(overflow), 64'(ovf));
    endtask

    // Read-port monitor: one-cycle latency and scoreboard compare.
    always @(negedge clk) begin
        rd_exp_t x;
        if (rd_valid || req_prev) begin
            check("rd_valid_latency", 64'(rd_valid), 64'(req_prev));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 64'(1), 64'(0));
                end else begin
                    x = exp_q.pop_front();
                    check("rd_err",  64'(rd_err),    64'(x.err));
                    check("rd_pc",   64'(rd_pc),     64'(x.ent.pc));
                    check("rd_op",   64'(rd_opcode), 64'(x.ent.op));
                    check("rd_data", 64'(rd_data),   64'(x.ent.data));
                end
            end
        end
        req_prev = rd_req;
    end

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 2'd0; trig_pc = '0;
        sample_valid = 1'b0; sample_pc = '0; sample_opcode = '0; sample_data = '0;
        rd_req = 1'b0; rd_idx = '0;
        step(); step();
        chk_status("por", 0, 0, 1'b0, 1'b0);
        check("por_rd_valid", 64'(rd_valid), 64'(0));
        reset = 1'b1;
        step();

        // Reset mid-capture
        start(2'd0);
        for (int i = 0; i < 5; i++) send(i, 1'b1);
        check("t1_pre_count", 64'(count), 64'(5));
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        chk_status("t1_async", 0, 0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        mdl.delete();
        step();
        chk_status("t1_post", 0, 0, 1'b0, 1'b0);
        rd(0);
        step(); step();

        // Free-run wrap
        start(2'd0);
        for (int i = 0; i < 20; i++) begin
            send(i, 1'b1);
            mdl_push(i);
        end
        chk_status("t2", 1, 16, 1'b0, 1'b1);
        rd(0); rd(15); rd(7);
        step(); step();

        // Stop on trigger, 8 post samples
        trig_pc = 12'd7;
        start(2'd1);
        for (int i = 0; i <= 30; i++) begin
            send(i, 1'b1);
            if (i <= 15) mdl_push(i);
            if (i == 7)  check("t3_post_state", 64'(state), 64'(2));
            if (i == 14) check("t3_pre_done",   64'(state), 64'(2));
            if (i == 15) check("t3_done",       64'(state), 64'(3));
        end
        chk_status("t3", 3, 16, 1'b1, 1'b0);
        rd(0); rd(15);
        step(); step();

        // Zero post-trigger with gaps in sample_valid
        trig_pc = 12'd3;
        start(2'd1);
        send(0, 1'b1);
        send(9, 1'b0);
        send(1, 1'b1);
        send(2, 1'b1);
        send(9, 1'b0);
        check("t4_armed", 64'(z_state), 64'(1));
        send(3, 1'b1);
        check("t4_done",  64'(z_state), 64'(3));
        check("t4_count", 64'(z_count), 64'(4));
        check("t4_trig",  64'(z_triggered), 64'(1));
        send(4, 1'b1);
        check("t4_frozen", 64'(z_count), 64'(4));

        // Enable dropped mid-capture, then restart
        trig_pc = 12'd51;
        start(2'd1);
        send(50, 1'b1); mdl_push(50);
        send(51, 1'b1); mdl_push(51);
        enable = 1'b0;
        send(52, 1'b1); mdl_push(52);
        chk_status("t6_drop", 0, 3, 1'b1, 1'b0);
        send(53, 1'b1);
        check("t6_idle_nowrite", 64'(count), 64'(3));
        rd(2); rd(3);
        step(); step();
        start(2'd1);
        chk_status("t6_restart", 1, 0, 1'b0, 1'b0);

        // Stop when full
        start(2'd2);
        for (int i = 100; i <= 120; i++) begin
            send(i, 1'b1);
            if (i <= 115) mdl_push(i);
            if (i == 114) check("t5_pre_done", 64'(state), 64'(1));
        end
        chk_status("t5", 3, 16, 1'b0, 1'b0);
        rd(15); rd(0);
        step(); step(); step();

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Hardware capture buffer for processor pipeline writeback events (PC, opcode, writeback data), replacing per-cycle simulation printouts with a synthesizable, readable on-chip trace. Sits beside the processor, samples one event per valid cycle into a circular RAM, and supports free-run, trigger-stop and fill-stop modes. Contents are read back by index through a 1-cycle-latency port to a debug/display path.

Parameters:
PC_W, 12, width of captured PC field
DATA_W, 32, width of captured writeback data
DEPTH_LOG2, 4, log2 of buffer entries (DEPTH = 2**DEPTH_LOG2)
POST_TRIG, 8, samples stored after the trigger sample in mode 1; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all control state
enable  in  1  arm capture; rising edge starts a new capture
mode  in  2  0 free-run, 1 stop-on-trigger, 2 stop-when-full, 3 reserved (treated as 0)
trig_pc  in  PC_W  trigger PC compare value
sample_valid  in  1  event present this cycle
sample_pc  in  PC_W  event PC
sample_opcode  in  5  event opcode
sample_data  in  DATA_W  event writeback data
rd_req  in  1  read request
rd_idx  in  DEPTH_LOG2  entry index, 0 = oldest stored entry
rd_valid  out  1  read result valid
rd_err  out  1  read index >= count
rd_pc  out  PC_W  read PC
rd_opcode  out  5  read opcode
rd_data  out  DATA_W  read data
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  out  DEPTH_LOG2+1  stored entries, saturates at DEPTH
triggered  out  1  sticky, trigger seen this capture
overflow  out  1  sticky, at least one entry overwritten

Behaviour:
- Reset (async, active-low): state=IDLE, count=0, wr_ptr=0, post_cnt=0, triggered=0, overflow=0, rd_valid=0, rd_err=0, rd_pc/rd_opcode/rd_data=0. RAM contents undefined; unreadable since count=0.
- IDLE: no capture. On enable 0->1 (registered edge detect): clear count, wr_ptr, post_cnt, triggered, overflow; go ARMED. Mode sampled at this edge, held for the capture.
- ARMED: each cycle with sample_valid=1 writes {pc,opcode,data} at wr_ptr, wr_ptr+1 mod DEPTH, count+1 saturating at DEPTH; a write when count==DEPTH sets overflow. Writes occur in the same cycle the sample is presented (entry readable from the next cycle).
- Mode 0: stays ARMED; trigger ignored; wraps indefinitely.
- Mode 1: a valid sample with sample_pc==trig_pc is stored, sets triggered, goes POST (post_cnt=0). If POST_TRIG=0, goes DONE directly instead.
- POST: each further valid sample stored and post_cnt+1; the sample making post_cnt==POST_TRIG goes DONE. PC matches in POST are ignored.
- Mode 2: the write that makes count==DEPTH goes DONE; no wrap, overflow never set.
- DONE: no writes; contents frozen. enable 0->1 restarts as from IDLE.
- enable=0 in ARMED/POST: go IDLE next cycle; contents, count, flags retained. A sample on that same cycle is still stored.
- Oldest entry = (wr_ptr - count) mod DEPTH. Read: rd_req at cycle N -> rd_valid=1 at N+1 with entry rd_idx relative to oldest; if rd_idx>=count, rd_err=1 and data fields 0. rd_valid=0 when no request. Reads legal in every state; a read and a write of the same slot in one cycle return the old contents.
- Simultaneous reset and any input: reset wins.

Test Plan:
- Reset mid-capture (mode 0, 5 samples stored, reset low 1 cycle) -> state=0, count=0, flags 0, read idx 0 gives rd_err=1.
- Mode 0, 20 samples pc=0..19 -> count=16, overflow=1, idx0 reads pc=4, idx15 reads pc=19, state stays 1.
- Mode 1, trig_pc=7, POST_TRIG=8, samples pc=0..30 -> DONE after pc=15, count=16, triggered=1, idx0 pc=0, idx15 pc=15, further samples ignored.
- Mode 1 POST_TRIG=0, trig_pc=3, samples pc=0.. with gaps in sample_valid -> DONE on cycle after pc=3 stored, count=4.
- Mode 2, samples pc=100..120 -> DONE after pc=115, count=16, overflow=0, idx15 reads pc=115, idx0 rd_valid one cycle after rd_req.
- enable dropped after 3 samples then re-raised -> IDLE with count=3 retained, then restart clears count=0, triggered=0.
